// File: rtl/move_sched.sv
// -----------------------------------------------------------------------------
// move_sched
//
// Movement scheduler for the maze game. A free-running divider produces a
// movement tick; on each tick (unless frozen) a six-state sequence moves the
// player sprite and then the ghost, both through one shared legality check,
// and finally tests for the player being caught.
//
// Ports:
//   clk        board clock, all logic on its rising edge
//   rst_n      synchronous active-low reset
//   btn_up/down/left/right  asynchronous player direction requests
//   freeze     high: movement ticks are ignored
//   player_x/y player centre position (10 / 9 bits)
//   ghost_x/y  ghost centre position (10 / 9 bits)
//   ghost_dir  ghost heading: 0=up, 1=right, 2=down, 3=left
//   busy       high while an update sequence is running
//   caught     one-cycle pulse when player and ghost coincide
// -----------------------------------------------------------------------------
module move_sched #(
    parameter int TICK_DIV  = 5_000_000,
    parameter int STEP      = 10,
    parameter int P_START_X = 50,
    parameter int P_START_Y = 50,
    parameter int G_START_X = 390,
    parameter int G_START_Y = 390
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       freeze,
    output logic [9:0] player_x,
    output logic [8:0] player_y,
    output logic [9:0] ghost_x,
    output logic [8:0] ghost_y,
    output logic [1:0] ghost_dir,
    output logic       busy,
    output logic       caught
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    // Maze geometry: corridors along x or y = 50, 220, 390 inside a 50..390 box.
    localparam logic signed [10:0] C_LO   = 11'sd50;
    localparam logic signed [10:0] C_MID  = 11'sd220;
    localparam logic signed [10:0] C_HI   = 11'sd390;
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    localparam logic [1:0] DIR_LEFT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CHK_P,
        COM_P,
        CHK_G,
        COM_G,
        COLL
    } state_t;

    // Shared legality check: inside the box and on at least one corridor.
    function automatic logic is_legal(input logic signed [10:0] cx,
                                      input logic signed [10:0] cy);
        logic in_box;
        logic on_row;
        logic on_col;
        in_box = (cx >= C_LO) && (cx <= C_HI) && (cy >= C_LO) && (cy <= C_HI);
        on_col = (cx == C_LO) || (cx == C_MID) || (cx == C_HI);
        on_row = (cy == C_LO) || (cy == C_MID) || (cy == C_HI);
        return in_box && (on_col || on_row);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sync1_q, sync2_q;   // {up, down, left, right}
    logic [9:0]       player_x_q, player_x_d;
    logic [8:0]       player_y_q, player_y_d;
    logic [9:0]       ghost_x_q, ghost_x_d;
    logic [8:0]       ghost_y_q, ghost_y_d;
    logic [1:0]       ghost_dir_q, ghost_dir_d;
    logic             legal_q, legal_d;
    logic [9:0]       cand_x_q, cand_x_d;
    logic [8:0]       cand_y_q, cand_y_d;
    logic             caught_q, caught_d;

    logic             tick;
    logic signed [10:0] px_s, py_s, gx_s, gy_s;
    logic signed [10:0] pcx, pcy, gcx, gcy;
    logic signed [10:0] chk_x, chk_y;
    logic             chk_legal;

    assign tick = (cnt_q == CNT_MAX);

    // Candidate arithmetic is widened to 11-bit signed so a step below zero
    // stays negative and is rejected instead of wrapping to a large value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        px_s = signed'({1'b0, player_x_q});
        py_s = signed'({2'b0, player_y_q});
        gx_s = signed'({1'b0, ghost_x_q});
        gy_s = signed'({2'b0, ghost_y_q});

        pcx = px_s;
        pcy = py_s;
        // Fixed priority U > D > L > R; a blocked choice does not fall back.
        if (sync2_q[3])      pcy = py_s - STEP_S;
        else if (sync2_q[2]) pcy = py_s + STEP_S;
        else if (sync2_q[1]) pcx = px_s - STEP_S;
        else if (sync2_q[0]) pcx = px_s + STEP_S;

        gcx = gx_s;
        gcy = gy_s;
        case (ghost_dir_q)
            2'd0:    gcy = gy_s - STEP_S;
            2'd1:    gcx = gx_s + STEP_S;
            2'd2:    gcy = gy_s + STEP_S;
            default: gcx = gx_s - STEP_S;
        endcase

        // One check unit, steered by which sprite is being evaluated.
        if (state_q == CHK_G) begin
            chk_x = gcx;
            chk_y = gcy;
        end else begin
            chk_x = pcx;
            chk_y = pcy;
        end
        chk_legal = is_legal(chk_x, chk_y);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
        player_x_d  = player_x_q;
        player_y_d  = player_y_q;
        ghost_x_d   = ghost_x_q;
        ghost_y_d   = ghost_y_q;
        ghost_dir_d = ghost_dir_q;
        legal_d     = legal_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        caught_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick arriving mid-sequence is simply never seen here.
                if (tick && !freeze) state_d = CHK_P;
            end
            CHK_P: begin
                legal_d  = chk_legal;
                cand_x_d = chk_x[9:0];
                cand_y_d = chk_y[8:0];
                state_d  = COM_P;
            end
            COM_P: begin
                if (legal_q) begin
                    player_x_d = cand_x_q;
                    player_y_d = cand_y_q;
                end
                state_d = CHK_G;
            end
            CHK_G: begin
                legal_d  = chk_legal;
                cand_x_d = chk_x[9:0];
                cand_y_d = chk_y[8:0];
                state_d  = COM_G;
            end
            COM_G: begin
                if (legal_q) begin
                    ghost_x_d = cand_x_q;
                    ghost_y_d = cand_y_q;
                end else begin
                    ghost_dir_d = ghost_dir_q + 2'd1;   // turn clockwise
                end
                state_d = COLL;
            end
            COLL: begin
                if ((player_x_q == ghost_x_q) && (player_y_q == ghost_y_q)) begin
                    caught_d    = 1'b1;
                    player_x_d  = 10'(P_START_X);
                    player_y_d  = 9'(P_START_Y);
                    ghost_x_d   = 10'(G_START_X);
                    ghost_y_d   = 9'(G_START_Y);
                    ghost_dir_d = DIR_LEFT;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            player_x_q  <= 10'(P_START_X);
            player_y_q  <= 9'(P_START_Y);
            ghost_x_q   <= 10'(G_START_X);
            ghost_y_q   <= 9'(G_START_Y);
            ghost_dir_q <= DIR_LEFT;
            legal_q     <= 1'b0;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            caught_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= {btn_up, btn_down, btn_left, btn_right};
            sync2_q     <= sync1_q;
            player_x_q  <= player_x_d;
            player_y_q  <= player_y_d;
            ghost_x_q   <= ghost_x_d;
            ghost_y_q   <= ghost_y_d;
            ghost_dir_q <= ghost_dir_d;
            legal_q     <= legal_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            caught_q    <= caught_d;
        end
    end

    assign player_x  = player_x_q;
    assign player_y  = player_y_q;
    assign ghost_x   = ghost_x_q;
    assign ghost_y   = ghost_y_q;
    assign ghost_dir = ghost_dir_q;
    assign busy      = (state_q != IDLE);
    assign caught    = caught_q;

endmodule

// File: tb/tb_move_sched.sv
// -----------------------------------------------------------------------------
// tb_move_sched
//
// Self-checking bench for move_sched with an 8-clock tick. Directed vectors
// walk the player and ghost through moves, blocking, the ghost turn at the
// corner and the catch, with hand-computed expected positions.
// -----------------------------------------------------------------------------
module tb_move_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       freeze;
    logic [9:0] player_x;
    logic [8:0] player_y;
    logic [9:0] ghost_x;
    logic [8:0] ghost_y;
    logic [1:0] ghost_dir;
    logic       busy;
    logic       caught;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    move_sched #(
        .TICK_DIV (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .freeze    (freeze),
        .player_x  (player_x),
        .player_y  (player_y),
        .ghost_x   (ghost_x),
        .ghost_y   (ghost_y),
        .ghost_dir (ghost_dir),
        .busy      (busy),
        .caught    (caught)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle samples of one update sequence, index k = cycle T+k.
    int s_px[7], s_py[7], s_gx[7], s_gy[7], s_dir[7], s_busy[7], s_caught[7];
    int caught_seen;

    // Waits (bounded) for busy, then samples cycles T+1..T+6 on falling edges.
    // Returns at the falling edge of T+6.
    task automatic run_tick();
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b1) begin
            check("busy_rise_timeout", int'(busy === 1'b1), 1);
            return;
        end
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            s_px[k]     = int'(player_x);
            s_py[k]     = int'(player_y);
            s_gx[k]     = int'(ghost_x);
            s_gy[k]     = int'(ghost_y);
            s_dir[k]    = int'(ghost_dir);
            s_busy[k]   = int'(busy);
            s_caught[k] = int'(caught);
            caught_seen += int'(caught);
        end
    endtask

    typedef struct {
        logic up, down, left, right;
        int   ticks;
        int   px, py, gx, gy, dir;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        int busy_seen;

        // {up, down, left, right, ticks, player x/y, ghost x/y, ghost_dir}
        vecs[0] = '{0, 0, 0, 1,  2, 80, 50, 360, 390, 3};  // ticks 2-3
        vecs[1] = '{0, 0, 0, 0,  1, 80, 50, 350, 390, 3};  // released: no move
        vecs[2] = '{0, 0, 1, 0,  2, 60, 50, 330, 390, 3};  // back to (60,50)
        vecs[3] = '{0, 1, 0, 0,  1, 60, 50, 320, 390, 3};  // down off corridor
        vecs[4] = '{0, 0, 1, 0,  1, 50, 50, 310, 390, 3};  // corner
        vecs[5] = '{1, 0, 0, 1,  1, 50, 50, 300, 390, 3};  // up wins, blocked
        vecs[6] = '{0, 0, 0, 0, 25, 50, 50,  50, 390, 3};  // tick 34
        vecs[7] = '{0, 0, 0, 0,  1, 50, 50,  50, 390, 0};  // tick 35: turn
        vecs[8] = '{0, 0, 0, 0,  1, 50, 50,  50, 380, 0};  // tick 36
        vecs[9] = '{0, 0, 0, 0, 32, 50, 50,  50,  60, 0};  // tick 68

        // Reset, with right already held so tick 1 moves the player.
        rst_n = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0001;
        freeze = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_player_x", int'(player_x), 50);
        check("rst_player_y", int'(player_y), 50);
        check("rst_ghost_x", int'(ghost_x), 390);
        check("rst_ghost_y", int'(ghost_y), 390);
        check("rst_ghost_dir", int'(ghost_dir), 3);
        check("rst_busy", int'(busy), 0);
        check("rst_caught", int'(caught), 0);

        n = 0;
        while (busy !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("rst_first_busy_delay", n, 8);

        // Tick 1: detailed cycle timing.
        caught_seen = 0;
        run_tick();
        check("t1_busy_window", s_busy[1] & s_busy[2] & s_busy[3] & s_busy[4] & s_busy[5], 1);
        check("t1_busy_drop", s_busy[6], 0);
        check("t1_px_T2_old", s_px[2], 50);
        check("t1_px_T3_new", s_px[3], 60);
        check("t1_py_T3", s_py[3], 50);
        check("t1_gx_T4_old", s_gx[4], 390);
        check("t1_gx_T5_new", s_gx[5], 380);
        check("t1_no_caught", caught_seen, 0);

        // Table-driven ticks 2..68.
        for (int i = 0; i < 10; i++) begin
            {btn_up, btn_down, btn_left, btn_right} =
                {vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right};
            caught_seen = 0;
            for (int t = 0; t < vecs[i].ticks; t++) run_tick();
            check($sformatf("v%0d_player_x", i), int'(player_x), vecs[i].px);
            check($sformatf("v%0d_player_y", i), int'(player_y), vecs[i].py);
            check($sformatf("v%0d_ghost_x", i), int'(ghost_x), vecs[i].gx);
            check($sformatf("v%0d_ghost_y", i), int'(ghost_y), vecs[i].gy);
            check($sformatf("v%0d_ghost_dir", i), int'(ghost_dir), vecs[i].dir);
            check($sformatf("v%0d_no_caught", i), caught_seen, 0);
        end

        // Tick 69: ghost lands on the player.
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        caught_seen = 0;
        run_tick();
        check("catch_gx_T5", s_gx[5], 50);
        check("catch_gy_T5", s_gy[5], 50);
        check("catch_caught_T5", s_caught[5], 0);
        check("catch_caught_T6", s_caught[6], 1);
        check("catch_ghost_x_T6", s_gx[6], 390);
        check("catch_ghost_y_T6", s_gy[6], 390);
        check("catch_dir_T6", s_dir[6], 3);
        check("catch_player_x_T6", s_px[6], 50);
        check("catch_player_y_T6", s_py[6], 50);
        @(negedge clk);
        check("catch_caught_T7", int'(caught), 0);
        check("catch_pulse_count", caught_seen, 1);

        // Freeze across 4 ticks.
        freeze = 1'b1;
        busy_seen = 0;
        repeat (32) begin
            @(negedge clk);
            busy_seen |= int'(busy);
        end
        check("freeze_busy", busy_seen, 0);
        check("freeze_ghost_x", int'(ghost_x), 390);
        check("freeze_ghost_dir", int'(ghost_dir), 3);
        check("freeze_player_x", int'(player_x), 50);

        // Reset during COM_P with right held: the move must not survive.
        freeze = 1'b0;
        btn_right = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_busy_seen", int'(busy), 1);
        @(negedge clk);                 // now in COM_P
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_player_x", int'(player_x), 50);
        check("abort_busy", int'(busy), 0);
        check("abort_ghost_x", int'(ghost_x), 390);
        btn_right = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_player_x_after", int'(player_x), 50);
        check("abort_busy_after", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", total);
        $fatal(1, "watchdog expired");
    end

endmodule
